// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard/flush sequencer.
package hazard_flush_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 4;
  localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;

  // One in-flight destination register.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dest;
  } sb_entry_t;

  // Pipeline control word driven to the datapath.
  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_exe_bubble;
    logic pipe_freeze;
  } ctrl_t;

  // All-zero control word: pipeline flows, nothing squashed.
  localparam ctrl_t CTRL_NOP = '0;

  // R15 is never a hazard source: the PC is not written via writeback.
  function automatic logic src_match(input sb_entry_t e, input logic [REG_IDX_W-1:0] src);
    return e.valid && (e.dest == src) && (src != PC_IDX);
  endfunction

endpackage

// File: rtl/hazard_flush_ctrl_scoreboard.sv
// Shift-register table of in-flight destinations (EXE, MEM, WB) plus RAW match.
module hazard_flush_ctrl_scoreboard
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned WB_BYPASS  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_shift,
  input  logic                 i_push_valid,
  input  logic [REG_IDX_W-1:0] i_push_dest,
  input  logic                 i_id_valid,
  input  logic [REG_IDX_W-1:0] i_src1,
  input  logic [REG_IDX_W-1:0] i_src2,
  input  logic                 i_two_src,
  output logic                 o_hazard
);

  // With write-before-read in the regfile the oldest (WB) entry cannot cause a hazard.
  localparam int unsigned NumChk = (WB_BYPASS != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

  sb_entry_t r_entries [PIPE_DEPTH];
  logic      w_hit;

  // Shift the table one stage per advancing cycle; the oldest entry retires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
        r_entries[i] <= '0;
      end
    end else if (i_shift) begin
      r_entries[0] <= '{valid: i_push_valid, dest: i_push_dest};
      for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
        r_entries[i] <= r_entries[i-1];
      end
    end
  end

  // Compare the ID sources against every checked entry.
  always_comb begin
    w_hit = 1'b0;
    for (int unsigned i = 0; i < NumChk; i++) begin
      if (src_match(r_entries[i], i_src1) || (i_two_src && src_match(r_entries[i], i_src2))) begin
        w_hit = 1'b1;
      end
    end
    o_hazard = i_id_valid & w_hit;
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencer beside ID: RAW stalls, branch flushes and memory-wait freezes.
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH   = 3,
  parameter int unsigned WB_BYPASS    = 0,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_id_valid,
  input  logic [REG_IDX_W-1:0] i_id_src1,
  input  logic [REG_IDX_W-1:0] i_id_src2,
  input  logic                 i_id_two_src,
  input  logic                 i_id_wb_en,
  input  logic [REG_IDX_W-1:0] i_id_dest,
  input  logic                 i_exe_branch_taken,
  input  logic                 i_mem_ready,
  output logic                 o_pc_freeze,
  output logic                 o_if_id_freeze,
  output logic                 o_if_id_flush,
  output logic                 o_id_exe_bubble,
  output logic                 o_pipe_freeze,
  output logic                 o_hazard,
  output logic [CNT_W-1:0]     o_stall_cnt,
  output logic [CNT_W-1:0]     o_flush_cnt
);

  localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

  state_e           r_state, w_state_d;
  state_e           r_resume, w_resume_d;
  state_e           w_cur;
  logic [1:0]       r_fcnt, w_fcnt_d;
  logic             r_started;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  ctrl_t w_ctrl;
  logic  w_active;
  logic  w_hazard;
  logic  w_flush_now;
  logic  w_stall_now;
  logic  w_shift;
  logic  w_push_valid;

  // Control stays quiet during reset and for the first cycle after release.
  assign w_active = r_started & ~i_rst;

  hazard_flush_ctrl_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .WB_BYPASS  (WB_BYPASS)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_shift      (w_shift),
    .i_push_valid (w_push_valid),
    .i_push_dest  (i_id_dest),
    .i_id_valid   (i_id_valid),
    .i_src1       (i_id_src1),
    .i_src2       (i_id_src2),
    .i_two_src    (i_id_two_src),
    .o_hazard     (w_hazard)
  );

  // FSM state, flush down-counter and the post-reset quiet flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_RUN;
      r_resume  <= ST_RUN;
      r_fcnt    <= '0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_resume  <= w_resume_d;
      r_fcnt    <= w_fcnt_d;
      r_started <= 1'b1;
    end
  end

  // Next-state and control decode; MEMWAIT beats FLUSH beats hazard stall.
  always_comb begin
    w_ctrl      = CTRL_NOP;
    w_state_d   = r_state;
    w_resume_d  = r_resume;
    w_fcnt_d    = r_fcnt;
    w_flush_now = 1'b0;
    w_stall_now = 1'b0;
    // Leaving MEMWAIT resumes whatever was running when the freeze started.
    w_cur       = (r_state == ST_MEMWAIT) ? r_resume : r_state;

    if (w_active) begin
      if (!i_mem_ready) begin
        w_ctrl.pipe_freeze  = 1'b1;
        w_ctrl.pc_freeze    = 1'b1;
        w_ctrl.if_id_freeze = 1'b1;
        w_state_d           = ST_MEMWAIT;
        w_resume_d          = w_cur;
      end else begin
        case (w_cur)
          // A bubbled EXE cannot branch, so the branch input is ignored here.
          ST_FLUSH: begin
            w_ctrl.if_id_flush   = 1'b1;
            w_ctrl.id_exe_bubble = 1'b1;
            w_flush_now          = 1'b1;
            w_fcnt_d             = r_fcnt - 2'd1;
            w_state_d            = (w_fcnt_d == 2'd0) ? ST_RUN : ST_FLUSH;
          end
          default: begin
            w_state_d = ST_RUN;
            if (i_exe_branch_taken) begin
              w_ctrl.if_id_flush   = 1'b1;
              w_ctrl.id_exe_bubble = 1'b1;
              w_flush_now          = 1'b1;
              w_fcnt_d             = FlushInit;
              w_state_d            = (FlushInit != 2'd0) ? ST_FLUSH : ST_RUN;
            end else if (w_hazard) begin
              w_ctrl.pc_freeze     = 1'b1;
              w_ctrl.if_id_freeze  = 1'b1;
              w_ctrl.id_exe_bubble = 1'b1;
              w_stall_now          = 1'b1;
            end
          end
        endcase
        w_resume_d = w_state_d;
      end
    end
  end

  // The table holds only while memory is stalled; stalled or flushed IDs enter as invalid.
  assign w_shift      = i_mem_ready | ~w_active;
  assign w_push_valid = w_active & i_id_valid & i_id_wb_en & ~w_hazard & ~w_flush_now;

  // Saturating performance counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_now && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_now && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pc_freeze     = w_ctrl.pc_freeze;
  assign o_if_id_freeze  = w_ctrl.if_id_freeze;
  assign o_if_id_flush   = w_ctrl.if_id_flush;
  assign o_id_exe_bubble = w_ctrl.id_exe_bubble;
  assign o_pipe_freeze   = w_ctrl.pipe_freeze;
  assign o_hazard        = w_hazard;
  assign o_stall_cnt     = r_stall_cnt;
  assign o_flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: vector table plus reset corner sequences.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_src, id_wb_en, br, mem_ready;
  logic [3:0] id_src1, id_src2, id_dest;

  logic        pcf, ifz, ifl, bub, pfz, haz;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pcf, s_ifz, s_ifl, s_bub, s_pfz, s_haz;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(
    .PIPE_DEPTH   (3),
    .WB_BYPASS    (0),
    .FLUSH_CYCLES (2),
    .CNT_W        (16)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_id_valid         (id_valid),
    .i_id_src1          (id_src1),
    .i_id_src2          (id_src2),
    .i_id_two_src       (id_two_src),
    .i_id_wb_en         (id_wb_en),
    .i_id_dest          (id_dest),
    .i_exe_branch_taken (br),
    .i_mem_ready        (mem_ready),
    .o_pc_freeze        (pcf),
    .o_if_id_freeze     (ifz),
    .o_if_id_flush      (ifl),
    .o_id_exe_bubble    (bub),
    .o_pipe_freeze      (pfz),
    .o_hazard           (haz),
    .o_stall_cnt        (stall_cnt),
    .o_flush_cnt        (flush_cnt)
  );

  // Narrow-counter copy: same stimulus, exposes saturation quickly.
  hazard_flush_ctrl #(
    .PIPE_DEPTH   (3),
    .WB_BYPASS    (0),
    .FLUSH_CYCLES (2),
    .CNT_W        (2)
  ) dut_sat (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_id_valid         (id_valid),
    .i_id_src1          (id_src1),
    .i_id_src2          (id_src2),
    .i_id_two_src       (id_two_src),
    .i_id_wb_en         (id_wb_en),
    .i_id_dest          (id_dest),
    .i_exe_branch_taken (br),
    .i_mem_ready        (mem_ready),
    .o_pc_freeze        (s_pcf),
    .o_if_id_freeze     (s_ifz),
    .o_if_id_flush      (s_ifl),
    .o_id_exe_bubble    (s_bub),
    .o_pipe_freeze      (s_pfz),
    .o_hazard           (s_haz),
    .o_stall_cnt        (s_stall_cnt),
    .o_flush_cnt        (s_flush_cnt)
  );

  // exp bits: {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze, hazard}
  typedef struct {
    logic       valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
    logic       wb;
    logic [3:0] dest;
    logic       br;
    logic       mr;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    logic [5:0]  bits;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                              input logic two, input logic wb, input logic [3:0] d,
                              input logic b, input logic mr, input logic [5:0] e);
    vec_t r;
    r.valid = v; r.src1 = s1; r.src2 = s2; r.two = two; r.wb = wb; r.dest = d;
    r.br = b; r.mr = mr; r.exp = e;
    return r;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_src1 = v.src1; id_src2 = v.src2; id_two_src = v.two;
    id_wb_en = v.wb; id_dest = v.dest; br = v.br; mem_ready = v.mr;
  endtask

  // Pop the oldest expectation and compare it with what the DUTs show now.
  task automatic sample(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_ctrl"}, {26'd0, pcf, ifz, ifl, bub, pfz, haz}, {26'd0, e.bits});
      check({tag, "_ctrl_sat"}, {26'd0, s_pcf, s_ifz, s_ifl, s_bub, s_pfz, s_haz},
            {26'd0, e.bits});
      check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, {16'd0, e.stall});
      check({tag, "_flush_cnt"}, {16'd0, flush_cnt}, {16'd0, e.flush});
    end
  endtask

  task automatic step(input vec_t v, input bit rel, input string tag);
    @(posedge clk);
    #1;
    if (rel) rst = 1'b0;
    drive(v);
    exp_q.push_back('{v.exp, 16'(m_stall), 16'(m_flush)});
    @(negedge clk);
    sample(tag);
    if (v.exp[5] && v.exp[2] && !v.exp[1]) m_stall++;
    if (v.exp[3] && !v.exp[1]) m_flush++;
  endtask

  // Asynchronous reset mid-cycle with inputs that would otherwise raise every output.
  task automatic hit_reset(input string tag);
    #2;
    rst = 1'b1;
    drive(mk(1, 1, 2, 1, 1, 4, 1, 0, 6'b0));
    m_stall = 0;
    m_flush = 0;
    #1;
    exp_q.push_back('{6'b0, 16'd0, 16'd0});
    sample(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b0));

    // Quiet first cycle after release, even with branch and memory stall asserted.
    tbl.push_back(mk(1, 5, 5, 1, 1, 5, 1, 0, 6'b000000));
    // RAW on R1: three stall cycles (EXE, MEM, WB).
    tbl.push_back(mk(1, 5, 3, 1, 1, 1, 0, 1, 6'b000000));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 1, 4, 0, 1, 6'b110101));
    tbl.push_back(mk(1, 1, 0, 0, 1, 4, 0, 1, 6'b000000));
    // No false hazards: unread src2, CMP without writeback, R15 source.
    tbl.push_back(mk(1, 7, 8, 0, 1, 1, 0, 1, 6'b000000));
    tbl.push_back(mk(1, 2, 1, 0, 1, 9, 0, 1, 6'b000000));
    tbl.push_back(mk(1, 5, 6, 1, 0, 10, 0, 1, 6'b000000));
    tbl.push_back(mk(1, 10, 11, 1, 1, 12, 0, 1, 6'b000000));
    tbl.push_back(mk(1, 0, 0, 0, 1, 15, 0, 1, 6'b000000));
    tbl.push_back(mk(1, 15, 15, 1, 0, 0, 0, 1, 6'b000000));
    // Real src2 hazard on R12 in WB.
    tbl.push_back(mk(1, 3, 12, 1, 0, 0, 0, 1, 6'b110101));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000));
    // Branch coinciding with hazard: flush wins, two bubbles, flushed dests not recorded.
    tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 1, 6'b000000));
    tbl.push_back(mk(1, 2, 0, 0, 1, 6, 1, 1, 6'b001101));
    tbl.push_back(mk(1, 0, 0, 0, 1, 7, 1, 1, 6'b001100));
    tbl.push_back(mk(1, 6, 7, 1, 1, 8, 0, 1, 6'b000000));
    // Memory wait for 4 cycles with R3 pending in MEM; R3 still pending afterwards.
    tbl.push_back(mk(1, 0, 0, 0, 1, 3, 0, 1, 6'b000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 6'b110011));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 6'b110101));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 6'b000000));
    // Memory wait in the middle of a flush keeps the remaining count.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 6'b001100));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b110010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b001100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000));
    // Fill the table with three valid entries.
    for (int i = 1; i <= 3; i++) tbl.push_back(mk(1, 0, 0, 0, 1, 4'(i), 0, 1, 6'b000000));

    #3;
    exp_q.push_back('{6'b0, 16'd0, 16'd0});
    sample("in_reset");

    foreach (tbl[i]) step(tbl[i], i == 0, $sformatf("vec%0d", i));

    check("sat_stall_cnt", {30'd0, s_stall_cnt}, (m_stall > 3) ? 32'd3 : 32'(m_stall));
    check("sat_flush_cnt", {30'd0, s_flush_cnt}, (m_flush > 3) ? 32'd3 : 32'(m_flush));

    // Reset with three valid entries: table and counters must come back empty.
    hit_reset("rst_full");
    step(mk(1, 1, 2, 1, 1, 4, 1, 0, 6'b000000), 1'b1, "rst_full_rel");
    step(mk(1, 3, 2, 1, 0, 0, 0, 1, 6'b000000), 1'b0, "rst_full_empty");

    // Reset in the middle of a flush: no bubble may survive.
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 6'b001100), 1'b0, "rst_flush_br");
    hit_reset("rst_flush");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000), 1'b1, "rst_flush_rel");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000), 1'b0, "rst_flush_gone");

    // Memory wait outranks a taken branch.
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b110010), 1'b0, "memwait_over_br");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000), 1'b0, "memwait_over_br_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
